// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared types, constants and helpers for the multi-channel
//                BCD alarm controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    // Width of one BCD digit
    localparam int BCD_W = 4;

    // Per-channel ring/snooze state
    typedef enum logic [1:0] {
        ALM_IDLE   = 2'd0,
        ALM_RING   = 2'd1,
        ALM_SNOOZE = 2'd2
    } alm_state_t;

    // HH:MM packed as {hour_10, hour_01, min_10, min_01}
    typedef logic [4*BCD_W-1:0] hhmm_t;

    // Ceiling log2; clog2(1) = 0, callers floor widths at 1 where needed
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : alarm_pkg
`default_nettype wire

// File: rtl/alarm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_channel
//  Description : One alarm channel: HH:MM register with arm bit, equality
//                comparator against the running clock, and the IDLE / RING /
//                SNOOZE state machine with its ring and snooze counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  hhmm_t            i_clock_hhmm,
    input  logic [BCD_W-1:0] i_clock_sec_10,
    input  logic [BCD_W-1:0] i_clock_sec_01,
    input  logic             i_wr_sel,
    input  hhmm_t            i_wr_hhmm,
    input  logic             i_wr_arm,
    input  logic             i_stop,
    input  logic             i_snooze,
    output logic             o_ringing,
    output logic             o_snoozing,
    output logic             o_armed,
    output logic             o_ring_next
);

    localparam int RC_W  = (clog2(RING_SEC + 1)   < 1) ? 1 : clog2(RING_SEC + 1);
    localparam int SZC_W = (clog2(SNOOZE_SEC + 1) < 1) ? 1 : clog2(SNOOZE_SEC + 1);
    localparam int SN_W  = (clog2(MAX_SNOOZE + 1) < 1) ? 1 : clog2(MAX_SNOOZE + 1);

    alm_state_t        r_state, w_state_nxt;
    hhmm_t             r_alarm;
    logic              r_arm;
    logic [RC_W-1:0]   r_ring_cnt,  w_ring_cnt_nxt;
    logic [SZC_W-1:0]  r_snz_cnt,   w_snz_cnt_nxt;
    logic [SN_W-1:0]   r_snz_num,   w_snz_num_nxt;
    logic              r_ringing;
    logic              r_snoozing;
    logic              w_match;

    // One match per alarm minute: only the tick that lands on second 00
    assign w_match = i_tick && r_arm && (i_clock_hhmm == r_alarm)
                     && (i_clock_sec_10 == '0) && (i_clock_sec_01 == '0);

    // Alarm register, state, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ALM_IDLE;
            r_alarm    <= '0;
            r_arm      <= 1'b0;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_snz_num  <= '0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            if (i_wr_sel) begin
                r_alarm <= i_wr_hhmm;
                r_arm   <= i_wr_arm;
            end
            r_state    <= w_state_nxt;
            r_ring_cnt <= w_ring_cnt_nxt;
            r_snz_cnt  <= w_snz_cnt_nxt;
            r_snz_num  <= w_snz_num_nxt;
            r_ringing  <= (w_state_nxt == ALM_RING);
            r_snoozing <= (w_state_nxt == ALM_SNOOZE);
        end
    end

    // Next state: write > stop > snooze > tick-driven transitions
    always_comb begin
        w_state_nxt    = r_state;
        w_ring_cnt_nxt = r_ring_cnt;
        w_snz_cnt_nxt  = r_snz_cnt;
        w_snz_num_nxt  = r_snz_num;
        if (i_wr_sel) begin
            w_state_nxt    = ALM_IDLE;
            w_ring_cnt_nxt = '0;
            w_snz_cnt_nxt  = '0;
            w_snz_num_nxt  = '0;
        end else begin
            case (r_state)
                ALM_IDLE: begin
                    // A stop pulse coinciding with the match suppresses it
                    if (w_match && !i_stop) begin
                        w_state_nxt    = ALM_RING;
                        w_ring_cnt_nxt = '0;
                        w_snz_cnt_nxt  = '0;
                        w_snz_num_nxt  = '0;
                    end
                end
                ALM_RING: begin
                    if (i_stop) begin
                        w_state_nxt    = ALM_IDLE;
                        w_ring_cnt_nxt = '0;
                        w_snz_cnt_nxt  = '0;
                        w_snz_num_nxt  = '0;
                    end else if (i_snooze) begin
                        if (r_snz_num < SN_W'(MAX_SNOOZE)) begin
                            w_state_nxt    = ALM_SNOOZE;
                            w_snz_num_nxt  = r_snz_num + SN_W'(1);
                            w_snz_cnt_nxt  = '0;
                            w_ring_cnt_nxt = '0;
                        end else begin
                            // Snooze budget spent: behaves as stop
                            w_state_nxt    = ALM_IDLE;
                            w_ring_cnt_nxt = '0;
                            w_snz_cnt_nxt  = '0;
                            w_snz_num_nxt  = '0;
                        end
                    end else if (i_tick) begin
                        if (r_ring_cnt == RC_W'(RING_SEC - 1)) begin
                            w_state_nxt    = ALM_IDLE;
                            w_ring_cnt_nxt = '0;
                            w_snz_cnt_nxt  = '0;
                            w_snz_num_nxt  = '0;
                        end else begin
                            w_ring_cnt_nxt = r_ring_cnt + RC_W'(1);
                        end
                    end
                end
                ALM_SNOOZE: begin
                    if (i_stop) begin
                        w_state_nxt    = ALM_IDLE;
                        w_ring_cnt_nxt = '0;
                        w_snz_cnt_nxt  = '0;
                        w_snz_num_nxt  = '0;
                    end else if (i_tick) begin
                        if (r_snz_cnt == SZC_W'(SNOOZE_SEC - 1)) begin
                            // Snooze count is kept so the limit spans the event
                            w_state_nxt    = ALM_RING;
                            w_ring_cnt_nxt = '0;
                            w_snz_cnt_nxt  = '0;
                        end else begin
                            w_snz_cnt_nxt = r_snz_cnt + SZC_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt    = ALM_IDLE;
                    w_ring_cnt_nxt = '0;
                    w_snz_cnt_nxt  = '0;
                    w_snz_num_nxt  = '0;
                end
            endcase
        end
    end

    assign o_ringing   = r_ringing;
    assign o_snoozing  = r_snoozing;
    assign o_armed     = r_arm;
    assign o_ring_next = (w_state_nxt == ALM_RING);

endmodule : alarm_channel
`default_nettype wire

// File: rtl/alarm_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_multi_ctrl
//  Description : N-channel BCD alarm controller. Decodes alarm register
//                writes, runs one alarm_channel per alarm and merges the
//                ringing channels into a single registered buzzer enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_multi_ctrl
    import alarm_pkg::*;
#(
    parameter int N_ALARM    = 4,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int IDX_W      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic [BCD_W-1:0]   clock_hour_10,
    input  logic [BCD_W-1:0]   clock_hour_01,
    input  logic [BCD_W-1:0]   clock_min_10,
    input  logic [BCD_W-1:0]   clock_min_01,
    input  logic [BCD_W-1:0]   clock_sec_10,
    input  logic [BCD_W-1:0]   clock_sec_01,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [BCD_W-1:0]   wr_hour_10,
    input  logic [BCD_W-1:0]   wr_hour_01,
    input  logic [BCD_W-1:0]   wr_min_10,
    input  logic [BCD_W-1:0]   wr_min_01,
    input  logic               wr_arm,
    input  logic               stop,
    input  logic               snooze,
    output logic [N_ALARM-1:0] ringing,
    output logic [N_ALARM-1:0] snoozing,
    output logic [N_ALARM-1:0] armed,
    output logic               buzzer_en
);

    hhmm_t              w_clock_hhmm;
    hhmm_t              w_wr_hhmm;
    logic [N_ALARM-1:0] w_wr_sel;
    logic [N_ALARM-1:0] w_ring_nxt;
    logic               r_buzzer;

    assign w_clock_hhmm = {clock_hour_10, clock_hour_01, clock_min_10, clock_min_01};
    assign w_wr_hhmm    = {wr_hour_10, wr_hour_01, wr_min_10, wr_min_01};

    // Only indices below N_ALARM decode, so out-of-range writes fall away
    generate
        for (genvar g = 0; g < N_ALARM; g++) begin : g_chan
            assign w_wr_sel[g] = wr_en && (wr_idx == IDX_W'(g));

            alarm_channel #(
                .RING_SEC   (RING_SEC),
                .SNOOZE_SEC (SNOOZE_SEC),
                .MAX_SNOOZE (MAX_SNOOZE)
            ) u_chan (
                .clk            (clk),
                .rst_n          (rst_n),
                .i_tick         (tick_1hz),
                .i_clock_hhmm   (w_clock_hhmm),
                .i_clock_sec_10 (clock_sec_10),
                .i_clock_sec_01 (clock_sec_01),
                .i_wr_sel       (w_wr_sel[g]),
                .i_wr_hhmm      (w_wr_hhmm),
                .i_wr_arm       (wr_arm),
                .i_stop         (stop),
                .i_snooze       (snooze),
                .o_ringing      (ringing[g]),
                .o_snoozing     (snoozing[g]),
                .o_armed        (armed[g]),
                .o_ring_next    (w_ring_nxt[g])
            );
        end
    endgenerate

    // Buzzer registered from next-state ring bits so it lines up with ringing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buzzer <= 1'b0;
        end else begin
            r_buzzer <= |w_ring_nxt;
        end
    end

    assign buzzer_en = r_buzzer;

endmodule : alarm_multi_ctrl
`default_nettype wire

// File: tb/tb_alarm_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_multi_ctrl
//  Description : Self-checking bench for alarm_multi_ctrl with three channels,
//                a 5 s snooze and a two-snooze limit. A vector table covers
//                writes, compares and stop/snooze priority; hand sequences
//                cover auto-stop, snooze return and limit, and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_multi_ctrl;

    localparam int N   = 3;
    localparam int NV  = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick_1hz;
    logic [3:0]   clock_hour_10, clock_hour_01, clock_min_10, clock_min_01;
    logic [3:0]   clock_sec_10, clock_sec_01;
    logic         wr_en;
    logic [1:0]   wr_idx;
    logic [3:0]   wr_hour_10, wr_hour_01, wr_min_10, wr_min_01;
    logic         wr_arm;
    logic         stop;
    logic         snooze;
    logic [N-1:0] ringing;
    logic [N-1:0] snoozing;
    logic [N-1:0] armed;
    logic         buzzer_en;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic         tick;
        logic [15:0]  hm;
        logic [7:0]   sec;
        logic         wr;
        logic [1:0]   idx;
        logic [15:0]  whm;
        logic         arm;
        logic         stp;
        logic         snz;
        logic [N-1:0] e_ring;
        logic [N-1:0] e_snz;
        logic [N-1:0] e_arm;
        logic         e_buz;
    } vec_t;

    vec_t tbl [NV];

    alarm_multi_ctrl #(
        .N_ALARM    (N),
        .RING_SEC   (30),
        .SNOOZE_SEC (5),
        .MAX_SNOOZE (2),
        .IDX_W      (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_1hz      (tick_1hz),
        .clock_hour_10 (clock_hour_10),
        .clock_hour_01 (clock_hour_01),
        .clock_min_10  (clock_min_10),
        .clock_min_01  (clock_min_01),
        .clock_sec_10  (clock_sec_10),
        .clock_sec_01  (clock_sec_01),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_hour_10    (wr_hour_10),
        .wr_hour_01    (wr_hour_01),
        .wr_min_10     (wr_min_10),
        .wr_min_01     (wr_min_01),
        .wr_arm        (wr_arm),
        .stop          (stop),
        .snooze        (snooze),
        .ringing       (ringing),
        .snoozing      (snoozing),
        .armed         (armed),
        .buzzer_en     (buzzer_en)
    );

    always #5 clk = ~clk;

    // Safety net in case the run never reaches its summary
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic t, input logic [15:0] hm, input logic [7:0] s,
                                input logic wr, input logic [1:0] idx, input logic [15:0] whm,
                                input logic arm, input logic sp, input logic sz,
                                input logic [N-1:0] er, input logic [N-1:0] es,
                                input logic [N-1:0] ea, input logic eb);
        vec_t v;
        v.tick = t;  v.hm = hm;   v.sec = s;
        v.wr = wr;   v.idx = idx; v.whm = whm; v.arm = arm;
        v.stp = sp;  v.snz = sz;
        v.e_ring = er; v.e_snz = es; v.e_arm = ea; v.e_buz = eb;
        return v;
    endfunction

    function automatic logic [7:0] bcd(input int s);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(s / 10);
        ones = 4'(s % 10);
        return {tens, ones};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [N-1:0] er,
                           input logic [N-1:0] es, input logic eb);
        chk({name, " ringing"},  8'(ringing),   8'(er));
        chk({name, " snoozing"}, 8'(snoozing),  8'(es));
        chk({name, " buzzer"},   8'(buzzer_en), 8'(eb));
    endtask

    // One clock cycle of stimulus; pulses drop right after the edge
    task automatic cyc(input logic t, input logic [15:0] hm, input logic [7:0] s,
                       input logic sp, input logic sz);
        tick_1hz = t;
        {clock_hour_10, clock_hour_01, clock_min_10, clock_min_01} = hm;
        {clock_sec_10, clock_sec_01} = s;
        stop   = sp;
        snooze = sz;
        wr_en  = 1'b0;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        stop     = 1'b0;
        snooze   = 1'b0;
    endtask

    initial begin
        // idx3 is out of range with three channels
        //                t   hhmm      sec    wr idx whhmm    arm sp sz  ring    snz     arm     buz
        tbl[0]  = mk(1'b0, 16'h0000, 8'h00, 1, 2'd1, 16'h0730, 1, 0, 0, 3'b000, 3'b000, 3'b010, 0);
        tbl[1]  = mk(1'b0, 16'h0000, 8'h00, 1, 2'd0, 16'h1200, 1, 0, 0, 3'b000, 3'b000, 3'b011, 0);
        tbl[2]  = mk(1'b0, 16'h0000, 8'h00, 1, 2'd2, 16'h1200, 1, 0, 0, 3'b000, 3'b000, 3'b111, 0);
        tbl[3]  = mk(1'b0, 16'h0000, 8'h00, 1, 2'd3, 16'h0000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0);
        tbl[4]  = mk(1'b1, 16'h1200, 8'h01, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0);
        tbl[5]  = mk(1'b1, 16'h0200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0);
        tbl[6]  = mk(1'b1, 16'h1201, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0);
        tbl[7]  = mk(1'b1, 16'h1200, 8'h10, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0);
        tbl[8]  = mk(1'b0, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0);
        tbl[9]  = mk(1'b1, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b101, 3'b000, 3'b111, 1);
        tbl[10] = mk(1'b1, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b101, 3'b000, 3'b111, 1);
        tbl[11] = mk(1'b0, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 1, 0, 3'b000, 3'b000, 3'b111, 0);
        tbl[12] = mk(1'b1, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b101, 3'b000, 3'b111, 1);
        tbl[13] = mk(1'b0, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 1, 1, 3'b000, 3'b000, 3'b111, 0);
        tbl[14] = mk(1'b1, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b101, 3'b000, 3'b111, 1);
        tbl[15] = mk(1'b0, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 1, 3'b000, 3'b101, 3'b111, 0);
        tbl[16] = mk(1'b0, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 1, 3'b000, 3'b101, 3'b111, 0);
        tbl[17] = mk(1'b1, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b000, 3'b101, 3'b111, 0);
        tbl[18] = mk(1'b0, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 1, 0, 3'b000, 3'b000, 3'b111, 0);
        tbl[19] = mk(1'b1, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b101, 3'b000, 3'b111, 1);
        tbl[20] = mk(1'b0, 16'h1200, 8'h00, 1, 2'd2, 16'h1200, 0, 0, 0, 3'b001, 3'b000, 3'b011, 1);
        tbl[21] = mk(1'b1, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'b001, 3'b000, 3'b011, 1);
        tbl[22] = mk(1'b0, 16'h1200, 8'h00, 0, 2'd0, 16'h0000, 0, 1, 0, 3'b000, 3'b000, 3'b011, 0);
        tbl[23] = mk(1'b0, 16'h1200, 8'h00, 1, 2'd2, 16'h1200, 1, 0, 0, 3'b000, 3'b000, 3'b111, 0);

        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        {clock_hour_10, clock_hour_01, clock_min_10, clock_min_01} = 16'h0000;
        {clock_sec_10, clock_sec_01} = 8'h00;
        wr_en  = 1'b0;
        wr_idx = 2'd0;
        {wr_hour_10, wr_hour_01, wr_min_10, wr_min_01} = 16'h0000;
        wr_arm = 1'b0;
        stop   = 1'b0;
        snooze = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk_out("reset", 3'b000, 3'b000, 1'b0);
        chk("reset armed", 8'(armed), 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors, one clock cycle each
        for (int k = 0; k < NV; k++) begin
            tick_1hz = tbl[k].tick;
            {clock_hour_10, clock_hour_01, clock_min_10, clock_min_01} = tbl[k].hm;
            {clock_sec_10, clock_sec_01} = tbl[k].sec;
            wr_en  = tbl[k].wr;
            wr_idx = tbl[k].idx;
            {wr_hour_10, wr_hour_01, wr_min_10, wr_min_01} = tbl[k].whm;
            wr_arm = tbl[k].arm;
            stop   = tbl[k].stp;
            snooze = tbl[k].snz;
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", k), tbl[k].e_ring, tbl[k].e_snz, tbl[k].e_buz);
            chk($sformatf("vec%0d armed", k), 8'(armed), 8'(tbl[k].e_arm));
        end
        wr_en    = 1'b0;
        tick_1hz = 1'b0;
        stop     = 1'b0;
        snooze   = 1'b0;

        // Basic ring on ch1 then auto-stop on the 30th tick (07:30:30)
        cyc(1'b1, 16'h0730, 8'h00, 1'b0, 1'b0);
        chk_out("ring start", 3'b010, 3'b000, 1'b1);
        for (int s = 1; s <= 30; s++) begin
            cyc(1'b1, 16'h0730, bcd(s), 1'b0, 1'b0);
            if (s < 30) begin
                chk(ringing[1] ? "" : $sformatf("ring hold s%0d", s), 8'(ringing), 8'h02);
            end else begin
                chk_out("auto stop", 3'b000, 3'b000, 1'b0);
            end
        end

        // Snooze limit: two snoozes return after 5 ticks, the third stops
        cyc(1'b1, 16'h0730, 8'h00, 1'b0, 1'b0);
        chk_out("snz ring", 3'b010, 3'b000, 1'b1);
        for (int r = 1; r <= 2; r++) begin
            cyc(1'b0, 16'h0730, 8'h00, 1'b0, 1'b1);
            chk_out($sformatf("snooze%0d", r), 3'b000, 3'b010, 1'b0);
            for (int s = 1; s <= 5; s++) begin
                cyc(1'b1, 16'h0730, bcd(s), 1'b0, 1'b0);
                if (s < 5) begin
                    chk($sformatf("snz%0d hold s%0d", r, s), 8'(snoozing), 8'h02);
                end else begin
                    chk_out($sformatf("rering%0d", r), 3'b010, 3'b000, 1'b1);
                end
            end
        end
        cyc(1'b0, 16'h0730, 8'h05, 1'b0, 1'b1);
        chk_out("snooze limit", 3'b000, 3'b000, 1'b0);

        // A fresh event restores the snooze budget; stop ends SNOOZE
        cyc(1'b1, 16'h0730, 8'h00, 1'b0, 1'b0);
        chk_out("fresh ring", 3'b010, 3'b000, 1'b1);
        cyc(1'b0, 16'h0730, 8'h00, 1'b0, 1'b1);
        chk_out("fresh snooze", 3'b000, 3'b010, 1'b0);
        cyc(1'b0, 16'h0730, 8'h00, 1'b1, 1'b0);
        chk_out("stop in snooze", 3'b000, 3'b000, 1'b0);

        // Snooze arriving with the 30th ring tick is honoured
        cyc(1'b1, 16'h0730, 8'h00, 1'b0, 1'b0);
        for (int s = 1; s <= 29; s++) begin
            cyc(1'b1, 16'h0730, bcd(s), 1'b0, 1'b0);
        end
        chk_out("ring at 29", 3'b010, 3'b000, 1'b1);
        cyc(1'b1, 16'h0730, 8'h30, 1'b0, 1'b1);
        chk_out("snooze at 30", 3'b000, 3'b010, 1'b0);
        cyc(1'b0, 16'h0730, 8'h30, 1'b1, 1'b0);

        // Asynchronous reset mid-ring, observed before any clock edge
        cyc(1'b1, 16'h1200, 8'h00, 1'b0, 1'b0);
        chk_out("pre reset", 3'b101, 3'b000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async reset", 3'b000, 3'b000, 1'b0);
        chk("async reset armed", 8'(armed), 8'h00);
        #3;
        rst_n = 1'b1;
        cyc(1'b1, 16'h1200, 8'h00, 1'b0, 1'b0);
        chk_out("after reset", 3'b000, 3'b000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_alarm_multi_ctrl
`default_nettype wire
